decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode stage between fetch and execute. It extracts the opcode from an `IW`-bit instruction and produces the full control bundle through a two-entry skid buffer with valid/ready handshakes on both sides. It adds flush support, illegal-opcode flagging and a halt state machine that drains the halt instruction to execute and then stops accepting input.

## Interface
Parameters:
- `IW`, 16, instruction width.
- `OPW`, 5, opcode width; opcode = `instr[IW-1 -: OPW]`; must satisfy `OPW <= IW`.

Ports:
- Reset is synchronous and active-high; there is one clock.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_instr` in IW: instruction from fetch.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts this cycle; a transfer occurs when `in_valid && in_ready`.
- `out_ready` in 1: execute accepts.
- `out_valid` out 1: control bundle valid.
- `out_instr` out IW: instruction passed through with its controls.
- `out_ctrl` out 19: packed control bundle (field order below).
- `out_ill` out 1: opcode not in the decode table.
- `flush` in 1: discard all buffered entries.
- `halted` out 1: sticky; high once the halt instruction has left the stage.

`out_ctrl` fields, MSB to LSB:
- regdst[1:0], zext, regwrt, bsrc[1:0], branch, aluop[1:0], alujmp, invb, inva, memwrt, immsrc, asrc, regsrc, dump.
- The remaining 2 bits are reserved and always 0.

## Operation
Decode is a pure function `decode_op(opcode) -> {ctrl, ill}`. Every field defaults to 0.
- `5'b00000` HALT: dump=1, is_halt.
- `5'b00001` NOP: all 0.
- `5'b01000` ADDI: regdst=01, bsrc=01, regwrt=1.
- `5'b01001` SUBI: as ADDI, plus inva=1.
- Any other opcode: all 0 and ill=1. The table grows in the package as the ISA is filled in; this block does not change.

The buffer holds two entries, MAIN and SKID, each storing {valid, instr, ctrl, ill, is_halt}.
- Decode happens at accept; the decoded result is what gets stored.
- The output is always driven from MAIN.
- When MAIN empties, SKID moves into MAIN.
- Accepting while MAIN is full and not draining writes into SKID.
- `in_ready = !SKID.valid && state==RUN`. It depends only on registers.

Halt FSM:
- RUN: accepting an is_halt instruction -> DRAIN.
- DRAIN: `in_ready=0`. When MAIN holds the halt and transfers out -> HALTED.
- HALTED: `in_ready=0`, `out_valid=0`, `halted=1`. Only `rst` leaves this state.

Flush:
- Next cycle, MAIN and SKID are invalid.
- An input presented in the same cycle as flush is dropped.
- DRAIN -> RUN, because the halt was speculative.
- HALTED is unaffected.

## Timing
- Reset values: MAIN/SKID invalid, state RUN, `out_valid=0`, `out_ill=0`, `out_ctrl=0`, `out_instr=0`, `halted=0`, `in_ready=1` in the first cycle after reset.
- Latency: an instruction accepted in cycle N is presented with `out_valid=1` in cycle N+1.
- Throughput: one per cycle while `out_ready=1`.
- Backpressure: once `out_valid` is high, `out_instr`, `out_ctrl` and `out_ill` hold stable until the transfer. At most one extra entry is accepted (into SKID), then `in_ready` falls.
- Accept and output transfer in the same cycle: handled with no bubble and no data loss. Order is strictly FIFO.
- Flush has priority over accept, transfer and the FSM in the same cycle. A `rst` in the middle of operation overrides everything.
- `halted` rises the cycle after the halt instruction transfers out.

## Structure
- Package `decode_pkg` holds the opcode localparams, the `ctrl_t` packed struct (the 19-bit layout above), the `CTRL_W` constant, the FSM state enum, and the `decode_op` function.
- Sub-module `decode_skid`: a generic two-entry skid buffer, parametrised on payload width. The FSM and decode stay in `decode_stage`.

## Test plan
- Reset, then stream ADDI (`16'h4000`), SUBI (`16'h4800`), NOP back-to-back with `out_ready=1` -> outputs on cycles 1, 2, 3. ADDI ctrl has regdst=01, bsrc=01, regwrt=1; SUBI has the same plus inva=1. `in_ready` stays 1 throughout.
- Hold `out_ready=0` and offer 3 instructions -> 2 accepted, `in_ready=0` after the second, `out_instr` stable. Release `out_ready` -> both emerge in order and the third is then accepted.
- Opcode `5'b10101` -> `out_ill=1`, `out_ctrl=0`.
- HALT followed by ADDI offered -> ADDI is not accepted. The halt emerges with dump=1, `halted=1` the cycle after its transfer, and `in_ready` and `out_valid` stay 0 until `rst`.
- Flush in the same cycle as an accept, with MAIN and SKID full and state DRAIN -> next cycle `out_valid=0`, state RUN, `in_ready=1`, and the offered input never appears.
- Assert `rst` with `halted=1` -> next cycle all outputs are at their reset values and `in_ready=1`.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: opcode values,
// the packed control bundle, the halt FSM state type and the decode table.
package decode_pkg;

  // Opcodes are held 32 bits wide so decode_op accepts any opcode width
  // up to 32 once the caller zero-extends it.
  localparam logic [31:0] OP_HALT = 32'b00000;
  localparam logic [31:0] OP_NOP  = 32'b00001;
  localparam logic [31:0] OP_ADDI = 32'b01000;
  localparam logic [31:0] OP_SUBI = 32'b01001;

  // Control bundle, MSB to LSB; the two LSBs are reserved and always zero.
  typedef struct packed {
    logic [1:0] regdst;
    logic       zext;
    logic       regwrt;
    logic [1:0] bsrc;
    logic       branch;
    logic [1:0] aluop;
    logic       alujmp;
    logic       invb;
    logic       inva;
    logic       memwrt;
    logic       immsrc;
    logic       asrc;
    logic       regsrc;
    logic       dump;
    logic [1:0] rsvd;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    ctrl_t ctrl;
    logic  ill;
    logic  is_halt;
  } dec_t;

  function automatic dec_t decode_op(input logic [31:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_HALT: begin
        d.ctrl.dump = 1'b1;
        d.is_halt   = 1'b1;
      end
      OP_NOP: ;
      OP_ADDI: begin
        d.ctrl.regdst = 2'b01;
        d.ctrl.bsrc   = 2'b01;
        d.ctrl.regwrt = 1'b1;
      end
      OP_SUBI: begin
        d.ctrl.regdst = 2'b01;
        d.ctrl.bsrc   = 2'b01;
        d.ctrl.regwrt = 1'b1;
        d.ctrl.inva   = 1'b1;
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_skid.sv
// Generic two-entry skid buffer (MAIN + SKID), FIFO ordered.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : invalidate both entries (wins over push/pop)
//   push_i        : write push_data_i this cycle (caller qualifies with ready)
//   pop_i         : MAIN leaves this cycle (caller qualifies with valid)
//   main_valid_o  : MAIN holds an entry
//   main_data_o   : MAIN payload, drives the consumer
//   skid_valid_o  : SKID holds an entry (buffer full)
module decode_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         main_valid_o,
  output logic [W-1:0] main_data_o,
  output logic         skid_valid_o
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || pop_i) begin
      // MAIN frees up: older SKID entry moves forward first to keep order.
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = push_i;
        if (push_i) skid_d = push_data_i;
      end else begin
        main_v_d = push_i;
        if (push_i) main_d = push_data_i;
      end
    end else if (push_i) begin
      skid_v_d = 1'b1;
      skid_d   = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign main_valid_o = main_v_q;
  assign main_data_o  = main_q;
  assign skid_valid_o = skid_v_q;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes at accept, buffers the
// result in a two-entry skid buffer and runs the halt FSM.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_instr/in_valid   : instruction from fetch; in_ready accepts it
//   out_ready           : execute accepts
//   out_valid/out_instr : decoded instruction to execute
//   out_ctrl/out_ill    : control bundle and illegal-opcode flag
//   flush               : discard buffered entries and the same-cycle input
//   halted              : sticky, set once the halt instruction has left
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IW-1:0]     out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_ill,
  input  logic              flush,
  output logic              halted
);

  localparam int unsigned PW = IW + $bits(dec_t);

  state_e        state_q, state_d;
  logic [OPW-1:0] opcode;
  dec_t          in_dec;
  logic          accept, out_xfer;
  logic          main_valid, skid_valid;
  logic [PW-1:0] push_data, main_data;
  logic [IW-1:0] main_instr;
  dec_t          main_dec;

  assign opcode    = in_instr[IW-1 -: OPW];
  assign in_dec    = decode_op(32'(opcode));
  assign push_data = {in_instr, in_dec};

  // in_ready depends on registers only; flush drops a same-cycle input.
  assign in_ready  = !skid_valid && (state_q == ST_RUN);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = main_valid && (state_q != ST_HALTED);
  assign out_xfer  = out_valid && out_ready;

  decode_skid #(.W(PW)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_i       (accept),
    .push_data_i  (push_data),
    .pop_i        (out_xfer),
    .main_valid_o (main_valid),
    .main_data_o  (main_data),
    .skid_valid_o (skid_valid)
  );

  assign {main_instr, main_dec} = main_data;
  assign out_instr = main_instr;
  assign out_ctrl  = main_dec.ctrl;
  assign out_ill   = main_dec.ill;
  assign halted    = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      // A flushed halt was speculative; HALTED itself is never undone.
      if (state_q == ST_DRAIN) state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    if (accept && in_dec.is_halt) state_d = ST_DRAIN;
        ST_DRAIN:  if (out_xfer && main_dec.is_halt) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_decode_stage;

  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] in_instr;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [18:0]   out_ctrl;
  logic          out_ill;
  logic          flush;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] C_ZERO = 32'h0;
  localparam logic [31:0] C_ADDI = 32'h2A000;
  localparam logic [31:0] C_SUBI = 32'h2A080;
  localparam logic [31:0] C_HALT = 32'h00004;

  decode_stage #(.IW(16), .OPW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_ctrl  (out_ctrl),
    .out_ill   (out_ill),
    .flush     (flush),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_ill"},   32'(out_ill),   32'd0);
    check({tag, " out_ctrl"},  32'(out_ctrl),  C_ZERO);
    check({tag, " out_instr"}, 32'(out_instr), 32'h0);
    check({tag, " halted"},    32'(halted),    32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] instr, input logic [31:0] ctrl);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " instr"}, 32'(out_instr), 32'(instr));
    check({tag, " ctrl"},  32'(out_ctrl),  ctrl);
  endtask

  initial begin
    rst = 1'b1; in_instr = '0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); step();
    rst = 1'b0;
    check_reset("reset");

    // Back-to-back stream, out_ready high.
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h4000;
    step(); expect_out("addi", 16'h4000, C_ADDI);
    check("stream rdy1", 32'(in_ready), 32'd1);
    in_instr = 16'h4800;
    step(); expect_out("subi", 16'h4800, C_SUBI);
    check("stream rdy2", 32'(in_ready), 32'd1);
    in_instr = 16'h0800;
    step(); expect_out("nop", 16'h0800, C_ZERO);
    check("nop ill", 32'(out_ill), 32'd0);
    in_valid = 1'b0;
    step(); check("stream idle", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third waits.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4001;
    step(); expect_out("bp A", 16'h4001, C_ADDI);
    check("bp rdy after A", 32'(in_ready), 32'd1);
    in_instr = 16'h4802;
    step(); check("bp rdy after B", 32'(in_ready), 32'd0);
    check("bp hold1", 32'(out_instr), 32'h4001);
    in_instr = 16'h0803;
    step(); check("bp hold2", 32'(out_instr), 32'h4001);
    check("bp rdy held", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step(); expect_out("bp B", 16'h4802, C_SUBI);
    check("bp rdy back", 32'(in_ready), 32'd1);
    step(); expect_out("bp C", 16'h0803, C_ZERO);
    in_valid = 1'b0;
    step(); check("bp drained", 32'(out_valid), 32'd0);

    // Illegal opcode 10101.
    in_valid = 1'b1; in_instr = 16'hA800;
    step(); check("ill flag", 32'(out_ill), 32'd1);
    check("ill ctrl", 32'(out_ctrl), C_ZERO);
    check("ill valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step(); check("ill gone", 32'(out_valid), 32'd0);

    // Halt, then ADDI offered and refused.
    in_valid = 1'b1; in_instr = 16'h0000;
    step(); expect_out("halt", 16'h0000, C_HALT);
    check("halt rdy", 32'(in_ready), 32'd0);
    check("halt not yet", 32'(halted), 32'd0);
    in_instr = 16'h4000;
    step(); check("halted set", 32'(halted), 32'd1);
    check("halted valid", 32'(out_valid), 32'd0);
    check("halted rdy", 32'(in_ready), 32'd0);
    step(); step();
    check("halted sticky", 32'(halted), 32'd1);
    check("halted valid2", 32'(out_valid), 32'd0);
    check("halted rdy2", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    check_reset("rst from halted");

    // Flush with MAIN+SKID full and a halt draining.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4005;
    step(); in_instr = 16'h0006;
    step(); check("pre-flush rdy", 32'(in_ready), 32'd0);
    check("pre-flush main", 32'(out_instr), 32'h4005);
    in_instr = 16'h4807; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush rdy", 32'(in_ready), 32'd1);
    check("flush halted", 32'(halted), 32'd0);
    step(); check("flush no ghost", 32'(out_valid), 32'd0);
    // Accept coinciding with flush in RUN is dropped.
    in_valid = 1'b1; in_instr = 16'h4808; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    check("flush drop", 32'(out_valid), 32'd0);
    step(); check("flush drop2", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 16'h4009;
    step(); expect_out("post-flush", 16'h4009, C_ADDI);
    in_valid = 1'b0;
    step(); check("post-flush halted", 32'(halted), 32'd0);
    check("post-flush rdy", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
